// File: rtl/ravenoc_pkg.sv
// Shared flit framing types and widths for the NI packet framer.
package ravenoc_pkg;

  localparam int FLIT_TYPE_W         = 2;
  localparam int FLIT_DATA_WIDTH_DEF = 32;
  localparam int FLIT_WIDTH          = FLIT_DATA_WIDTH_DEF + FLIT_TYPE_W;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'b00,
    BODY_FLIT = 2'b01,
    TAIL_FLIT = 2'b10
  } flit_type_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BODY = 1'b1
  } tx_state_t;

  // VC index width, never narrower than one bit.
  function automatic int vc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/router_if.sv
// Flit link between the NI and the local router port.
interface router_if #(
  parameter int FLIT_W = 34,
  parameter int VC_W   = 2
);

  typedef struct packed {
    logic [FLIT_W-1:0] fdata;
    logic [VC_W-1:0]   vc_id;
    logic              valid;
  } req_t;

  typedef struct packed {
    logic ready;
  } resp_t;

  req_t  req;
  resp_t resp;

  modport send_flit (output req, input resp);
  modport recv_flit (input req, output resp);

endinterface

// File: rtl/pkt_skid_buf.sv
// Two-entry valid/ready skid: registered output, ready derived from occupancy only.
module pkt_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             active;
  logic             push;
  logic             pop;

  // Ready stays low while in reset and for the reset-release edge itself.
  assign in_ready  = active & (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      active <= 1'b0;
    end else begin
      active <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pkt_framer.sv
// NI packet framer: length-driven TX flit framing and per-VC RX framing checks.
module pkt_framer
  import ravenoc_pkg::*;
#(
  parameter int  FLIT_DATA_WIDTH = 32,
  parameter int  N_VIRT_CHN      = 3,
  parameter int  PKT_WIDTH       = 8,
  parameter int  PKT_SZ_LSB      = 16,
  parameter bit  AUTO_ADD_PKT_SZ = 1'b1,
  localparam int FLIT_W          = FLIT_DATA_WIDTH + FLIT_TYPE_W,
  localparam int VC_W            = vc_width(N_VIRT_CHN)
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic [VC_W-1:0]            tx_vc,
  input  logic [PKT_WIDTH-1:0]       tx_pkt_sz,
  input  logic [FLIT_DATA_WIDTH-1:0] tx_data,
  router_if.send_flit                local_send,
  router_if.recv_flit                local_recv,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [VC_W-1:0]            rx_vc,
  output logic [FLIT_DATA_WIDTH-1:0] rx_data,
  output logic                       rx_last,
  output logic [N_VIRT_CHN-1:0]      rx_err,
  input  logic [N_VIRT_CHN-1:0]      err_clr
);

  // ---------------- TX ----------------
  tx_state_t                  tx_state, tx_state_d;
  logic [PKT_WIDTH-1:0]       tx_cnt, tx_cnt_d;
  logic [VC_W-1:0]            tx_vc_q, tx_vc_d, flit_vc;
  logic [FLIT_DATA_WIDTH-1:0] flit_payload;
  flit_type_t                 flit_type;
  logic                       tx_fire;
  logic                       tx_out_valid;
  logic [FLIT_W+VC_W-1:0]     tx_out_data;

  assign tx_fire = tx_valid & tx_ready;

  // Flit type, payload and VC for the beat currently offered.
  always_comb begin
    tx_state_d   = tx_state;
    tx_cnt_d     = tx_cnt;
    tx_vc_d      = tx_vc_q;
    flit_payload = tx_data;
    flit_type    = HEAD_FLIT;
    flit_vc      = tx_vc;
    unique case (tx_state)
      TX_IDLE: begin
        if (AUTO_ADD_PKT_SZ) flit_payload[PKT_SZ_LSB +: PKT_WIDTH] = tx_pkt_sz;
        if (tx_pkt_sz > PKT_WIDTH'(1)) begin
          tx_state_d = TX_BODY;
          tx_cnt_d   = tx_pkt_sz - 1'b1;
          tx_vc_d    = tx_vc;
        end
      end
      TX_BODY: begin
        flit_vc = tx_vc_q;
        if (tx_cnt == PKT_WIDTH'(1)) begin
          flit_type  = TAIL_FLIT;
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end else begin
          flit_type = BODY_FLIT;
          tx_cnt_d  = tx_cnt - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Framing state advances only on an accepted beat.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_vc_q  <= '0;
    end else if (tx_fire) begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_vc_q  <= tx_vc_d;
    end
  end

  pkt_skid_buf #(.WIDTH(FLIT_W + VC_W)) u_tx_skid (
    .clk       (clk),
    .arst      (arst),
    .in_valid  (tx_valid),
    .in_ready  (tx_ready),
    .in_data   ({flit_type, flit_payload, flit_vc}),
    .out_valid (tx_out_valid),
    .out_ready (local_send.resp.ready),
    .out_data  (tx_out_data)
  );

  assign local_send.req = {tx_out_data, tx_out_valid};

  // ---------------- RX ----------------
  logic                  rx_in_ready;
  logic [FLIT_W+VC_W-1:0] rx_out_data;
  logic [1:0]            rx_type;
  logic [PKT_WIDTH-1:0]  rx_size;
  logic                  rx_fire;
  logic [PKT_WIDTH-1:0]  rem   [N_VIRT_CHN];
  logic [PKT_WIDTH-1:0]  rem_d [N_VIRT_CHN];
  logic [N_VIRT_CHN-1:0] err_set;

  pkt_skid_buf #(.WIDTH(FLIT_W + VC_W)) u_rx_skid (
    .clk       (clk),
    .arst      (arst),
    .in_valid  (local_recv.req.valid),
    .in_ready  (rx_in_ready),
    .in_data   ({local_recv.req.fdata, local_recv.req.vc_id}),
    .out_valid (rx_valid),
    .out_ready (rx_ready),
    .out_data  (rx_out_data)
  );

  assign local_recv.resp = rx_in_ready;

  assign rx_type = rx_out_data[FLIT_W+VC_W-1 -: FLIT_TYPE_W];
  assign rx_data = rx_out_data[VC_W +: FLIT_DATA_WIDTH];
  assign rx_vc   = rx_out_data[VC_W-1:0];
  assign rx_size = rx_data[PKT_SZ_LSB +: PKT_WIDTH];
  assign rx_fire = rx_valid & rx_ready;
  assign rx_last = rx_valid & ((rx_type == TAIL_FLIT) |
                               ((rx_type == HEAD_FLIT) & (rx_size <= PKT_WIDTH'(1))));

  // Per-VC remaining-flit tracking; errors leave the counter untouched except on HEAD/TAIL.
  always_comb begin
    rem_d   = rem;
    err_set = '0;
    if (rx_fire) begin
      for (int unsigned i = 0; i < N_VIRT_CHN; i++) begin
        if (rx_vc == VC_W'(i)) begin
          unique case (rx_type)
            HEAD_FLIT: begin
              if (rem[i] != '0) err_set[i] = 1'b1;
              rem_d[i] = (rx_size == '0) ? '0 : rx_size - 1'b1;
            end
            BODY_FLIT: begin
              if (rem[i] <= PKT_WIDTH'(1)) err_set[i] = 1'b1;
              else                         rem_d[i]   = rem[i] - 1'b1;
            end
            TAIL_FLIT: begin
              if (rem[i] != PKT_WIDTH'(1)) err_set[i] = 1'b1;
              rem_d[i] = '0;
            end
            default: err_set[i] = 1'b1;
          endcase
        end
      end
    end
  end

  // Counters and sticky errors; a new error beats a same-cycle clear.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int unsigned i = 0; i < N_VIRT_CHN; i++) rem[i] <= '0;
      rx_err <= '0;
    end else begin
      rem    <= rem_d;
      rx_err <= (rx_err & ~err_clr) | err_set;
    end
  end

endmodule

// File: tb/tb_pkt_framer.sv
// Directed self-checking bench for pkt_framer.
module tb_pkt_framer;
  import ravenoc_pkg::*;

  logic        clk = 1'b0;
  logic        arst;
  logic        tx_valid, tx_ready;
  logic [1:0]  tx_vc;
  logic [7:0]  tx_pkt_sz;
  logic [31:0] tx_data;
  logic        rx_valid, rx_ready, rx_last;
  logic [1:0]  rx_vc;
  logic [31:0] rx_data;
  logic [2:0]  rx_err, err_clr;
  int          checks = 0;
  int          errors = 0;

  router_if #(.FLIT_W(34), .VC_W(2)) send_if ();
  router_if #(.FLIT_W(34), .VC_W(2)) recv_if ();

  always #5 clk = ~clk;

  pkt_framer #(
    .FLIT_DATA_WIDTH (32),
    .N_VIRT_CHN      (3),
    .PKT_WIDTH       (8),
    .PKT_SZ_LSB      (16),
    .AUTO_ADD_PKT_SZ (1'b1)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_vc      (tx_vc),
    .tx_pkt_sz  (tx_pkt_sz),
    .tx_data    (tx_data),
    .local_send (send_if),
    .local_recv (recv_if),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_vc      (rx_vc),
    .rx_data    (rx_data),
    .rx_last    (rx_last),
    .rx_err     (rx_err),
    .err_clr    (err_clr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic v, input logic [1:0] vc, input logic [7:0] sz, input logic [31:0] d);
    tx_valid  = v;
    tx_vc     = vc;
    tx_pkt_sz = sz;
    tx_data   = d;
  endtask

  task automatic drive_rx(input logic v, input logic [1:0] t, input logic [31:0] d, input logic [1:0] vc);
    recv_if.req.fdata = {t, d};
    recv_if.req.vc_id = vc;
    recv_if.req.valid = v;
  endtask

  task automatic test_reset;
    arst = 1'b0;
    set_beat(1'b0, 2'd0, 8'd0, 32'h0);
    drive_rx(1'b0, 2'b00, 32'h0, 2'd0);
    send_if.resp.ready = 1'b0;
    rx_ready = 1'b0;
    err_clr  = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready got %b exp 0", tx_ready); end
    checks++; if (send_if.req.valid !== 1'b0) begin errors++; $display("FAIL reset_send_valid got %b exp 0", send_if.req.valid); end
    checks++; if (recv_if.resp.ready !== 1'b0) begin errors++; $display("FAIL reset_recv_ready got %b exp 0", recv_if.resp.ready); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
    checks++; if (rx_last !== 1'b0) begin errors++; $display("FAIL reset_rx_last got %b exp 0", rx_last); end
    checks++; if (rx_data !== 32'h0) begin errors++; $display("FAIL reset_rx_data got %h exp 0", rx_data); end
    checks++; if (rx_err !== 3'b000) begin errors++; $display("FAIL reset_rx_err got %b exp 000", rx_err); end
    arst = 1'b1;
    tick;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL post_reset_tx_ready got %b exp 1", tx_ready); end
    checks++; if (recv_if.resp.ready !== 1'b1) begin errors++; $display("FAIL post_reset_recv_ready got %b exp 1", recv_if.resp.ready); end
    checks++; if (dut.tx_state !== TX_IDLE) begin errors++; $display("FAIL post_reset_state got %0d exp IDLE", dut.tx_state); end
  endtask

  task automatic test_tx_packet;
    logic [31:0] d  [4];
    logic [33:0] ef [4];
    d[0] = 32'hDEAD_BEEF; d[1] = 32'h1111_1111; d[2] = 32'h2222_2222; d[3] = 32'h3333_3333;
    ef[0] = {2'b00, 32'hDE04_BEEF};
    ef[1] = {2'b01, 32'h1111_1111};
    ef[2] = {2'b01, 32'h2222_2222};
    ef[3] = {2'b10, 32'h3333_3333};
    send_if.resp.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_beat(1'b1, 2'd2, 8'd4, d[i]);
      else        set_beat(1'b1, 2'd1, 8'd9, d[i]);
      #1;
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx4_ready beat %0d got %b exp 1", i, tx_ready); end
      tick;
      checks++; if (send_if.req.valid !== 1'b1 || send_if.req.fdata !== ef[i] || send_if.req.vc_id !== 2'd2)
        begin errors++; $display("FAIL tx4_flit %0d got v=%b f=%h vc=%0d exp v=1 f=%h vc=2", i, send_if.req.valid, send_if.req.fdata, send_if.req.vc_id, ef[i]); end
    end
    set_beat(1'b0, 2'd0, 8'd0, 32'h0);
    checks++; if (dut.tx_state !== TX_IDLE) begin errors++; $display("FAIL tx4_end_state got %0d exp IDLE", dut.tx_state); end
    tick;
    checks++; if (send_if.req.valid !== 1'b0) begin errors++; $display("FAIL tx4_drain got %b exp 0", send_if.req.valid); end
  endtask

  task automatic test_single_flit;
    logic [1:0]  vc [4];
    logic [7:0]  sz [4];
    logic [31:0] d  [4];
    logic [33:0] ef [4];
    logic [1:0]  ev [4];
    tx_state_t   es [4];
    vc[0] = 2'd0; sz[0] = 8'd1; d[0] = 32'h00FF_0000; ef[0] = {2'b00, 32'h0001_0000}; ev[0] = 2'd0; es[0] = TX_IDLE;
    vc[1] = 2'd1; sz[1] = 8'd0; d[1] = 32'hCAFE_F00D; ef[1] = {2'b00, 32'hCA00_F00D}; ev[1] = 2'd1; es[1] = TX_IDLE;
    vc[2] = 2'd2; sz[2] = 8'd2; d[2] = 32'h0000_0001; ef[2] = {2'b00, 32'h0002_0001}; ev[2] = 2'd2; es[2] = TX_BODY;
    vc[3] = 2'd0; sz[3] = 8'd5; d[3] = 32'h0000_0002; ef[3] = {2'b10, 32'h0000_0002}; ev[3] = 2'd2; es[3] = TX_IDLE;
    for (int i = 0; i < 4; i++) begin
      set_beat(1'b1, vc[i], sz[i], d[i]);
      tick;
      checks++; if (send_if.req.valid !== 1'b1 || send_if.req.fdata !== ef[i] || send_if.req.vc_id !== ev[i])
        begin errors++; $display("FAIL single_flit %0d got v=%b f=%h vc=%0d exp v=1 f=%h vc=%0d", i, send_if.req.valid, send_if.req.fdata, send_if.req.vc_id, ef[i], ev[i]); end
      checks++; if (dut.tx_state !== es[i]) begin errors++; $display("FAIL single_state %0d got %0d exp %0d", i, dut.tx_state, es[i]); end
    end
    set_beat(1'b0, 2'd0, 8'd0, 32'h0);
    tick;
  endtask

  task automatic test_backpressure;
    logic [33:0] ef [8];
    logic [33:0] prev_f;
    logic        prev_stall;
    logic        in_fire, out_fire;
    int          in_idx, out_idx, full_viol, hold_viol, full_seen;
    ef[0] = {2'b00, 32'h1208_5678};
    for (int i = 1; i < 7; i++) ef[i] = {2'b01, 32'h5500_0000 | 32'(i)};
    ef[7] = {2'b10, 32'h5500_0007};
    in_idx = 0; out_idx = 0; full_viol = 0; hold_viol = 0; full_seen = 0;
    prev_stall = 1'b0; prev_f = '0;
    for (int cyc = 0; cyc < 64 && out_idx < 8; cyc++) begin
      send_if.resp.ready = (cyc % 2 == 0);
      if (in_idx == 0)     set_beat(1'b1, 2'd1, 8'd8, 32'h1234_5678);
      else if (in_idx < 8) set_beat(1'b1, 2'd3, 8'd0, 32'h5500_0000 | 32'(in_idx));
      else                 set_beat(1'b0, 2'd0, 8'd0, 32'h0);
      #1;
      if (dut.u_tx_skid.count == 2'd2) begin
        full_seen++;
        if (tx_ready) full_viol++;
      end
      if (prev_stall && (send_if.req.valid !== 1'b1 || send_if.req.fdata !== prev_f)) hold_viol++;
      in_fire  = tx_valid & tx_ready;
      out_fire = send_if.req.valid & send_if.resp.ready;
      if (out_fire) begin
        checks++; if (send_if.req.fdata !== ef[out_idx] || send_if.req.vc_id !== 2'd1)
          begin errors++; $display("FAIL bp_flit %0d got f=%h vc=%0d exp f=%h vc=1", out_idx, send_if.req.fdata, send_if.req.vc_id, ef[out_idx]); end
        out_idx++;
      end
      prev_stall = send_if.req.valid & ~send_if.resp.ready;
      prev_f     = send_if.req.fdata;
      if (in_fire) in_idx++;
      tick;
    end
    set_beat(1'b0, 2'd0, 8'd0, 32'h0);
    send_if.resp.ready = 1'b1;
    checks++; if (out_idx != 8) begin errors++; $display("FAIL bp_count got %0d exp 8", out_idx); end
    checks++; if (full_viol != 0) begin errors++; $display("FAIL bp_ready_when_full got %0d exp 0", full_viol); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold got %0d exp 0", hold_viol); end
    checks++; if (full_seen == 0) begin errors++; $display("FAIL bp_full_reached got %0d exp >0", full_seen); end
    repeat (2) tick;
    checks++; if (send_if.req.valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b exp 0", send_if.req.valid); end
  endtask

  task automatic test_rx_interleave;
    logic [1:0]  t  [5];
    logic [31:0] d  [5];
    logic [1:0]  vc [5];
    logic        el [5];
    t[0] = 2'b00; d[0] = 32'h0003_00A0; vc[0] = 2'd0; el[0] = 1'b0;
    t[1] = 2'b00; d[1] = 32'h0002_00B0; vc[1] = 2'd1; el[1] = 1'b0;
    t[2] = 2'b01; d[2] = 32'h0000_00A1; vc[2] = 2'd0; el[2] = 1'b0;
    t[3] = 2'b10; d[3] = 32'h0000_00B1; vc[3] = 2'd1; el[3] = 1'b1;
    t[4] = 2'b10; d[4] = 32'h0000_00A2; vc[4] = 2'd0; el[4] = 1'b1;
    rx_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_rx(1'b1, t[k], d[k], vc[k]);
      tick;
      checks++; if (rx_valid !== 1'b1 || rx_data !== d[k] || rx_vc !== vc[k] || rx_last !== el[k])
        begin errors++; $display("FAIL rx_il %0d got v=%b d=%h vc=%0d last=%b exp v=1 d=%h vc=%0d last=%b", k, rx_valid, rx_data, rx_vc, rx_last, d[k], vc[k], el[k]); end
    end
    drive_rx(1'b0, 2'b00, 32'h0, 2'd0);
    repeat (2) tick;
    checks++; if (rx_err !== 3'b000) begin errors++; $display("FAIL rx_il_err got %b exp 000", rx_err); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_il_drain got %b exp 0", rx_valid); end
  endtask

  task automatic test_rx_error;
    rx_ready = 1'b1;
    // vc1 BODY with nothing open
    drive_rx(1'b1, 2'b01, 32'h0000_0BAD, 2'd1);
    tick;
    checks++; if (rx_valid !== 1'b1 || rx_data !== 32'h0000_0BAD || rx_last !== 1'b0)
      begin errors++; $display("FAIL rx_bad_body_fwd got v=%b d=%h last=%b exp v=1 d=00000bad last=0", rx_valid, rx_data, rx_last); end
    drive_rx(1'b0, 2'b00, 32'h0, 2'd0);
    tick;
    checks++; if (rx_err !== 3'b010) begin errors++; $display("FAIL rx_body_err got %b exp 010", rx_err); end
    // vc1 TAIL with rem 0 leaves together with a clear
    drive_rx(1'b1, 2'b10, 32'h0000_0C0D, 2'd1);
    tick;
    drive_rx(1'b0, 2'b00, 32'h0, 2'd0);
    checks++; if (rx_last !== 1'b1) begin errors++; $display("FAIL rx_bad_tail_last got %b exp 1", rx_last); end
    err_clr = 3'b010;
    tick;
    err_clr = 3'b000;
    checks++; if (rx_err !== 3'b010) begin errors++; $display("FAIL rx_err_wins got %b exp 010", rx_err); end
    err_clr = 3'b010;
    tick;
    err_clr = 3'b000;
    checks++; if (rx_err !== 3'b000) begin errors++; $display("FAIL rx_err_clr got %b exp 000", rx_err); end
    // size 0 head is a single-flit packet
    drive_rx(1'b1, 2'b00, 32'h0000_1234, 2'd2);
    tick;
    checks++; if (rx_last !== 1'b1 || rx_vc !== 2'd2) begin errors++; $display("FAIL rx_head0_last got last=%b vc=%0d exp last=1 vc=2", rx_last, rx_vc); end
    drive_rx(1'b0, 2'b00, 32'h0, 2'd0);
    tick;
    checks++; if (rx_err !== 3'b000) begin errors++; $display("FAIL rx_head0_err got %b exp 000", rx_err); end
    // head while packet still open on vc2
    drive_rx(1'b1, 2'b00, 32'h0003_0000, 2'd2);
    tick;
    drive_rx(1'b1, 2'b00, 32'h0002_0000, 2'd2);
    tick;
    drive_rx(1'b0, 2'b00, 32'h0, 2'd0);
    tick;
    checks++; if (rx_err !== 3'b100) begin errors++; $display("FAIL rx_head_err got %b exp 100", rx_err); end
    // RX backpressure holds the flit
    rx_ready = 1'b0;
    drive_rx(1'b1, 2'b00, 32'h0001_0055, 2'd0);
    tick;
    drive_rx(1'b0, 2'b00, 32'h0, 2'd0);
    tick;
    checks++; if (rx_valid !== 1'b1 || rx_data !== 32'h0001_0055 || rx_last !== 1'b1)
      begin errors++; $display("FAIL rx_hold got v=%b d=%h last=%b exp v=1 d=00010055 last=1", rx_valid, rx_data, rx_last); end
    rx_ready = 1'b1;
    tick;
    checks++; if (rx_valid !== 1'b0 || rx_err !== 3'b100) begin errors++; $display("FAIL rx_hold_release got v=%b err=%b exp v=0 err=100", rx_valid, rx_err); end
  endtask

  task automatic test_reset_mid;
    send_if.resp.ready = 1'b0;
    set_beat(1'b1, 2'd2, 8'd5, 32'h0000_0000);
    tick;
    set_beat(1'b1, 2'd2, 8'd5, 32'h0000_0001);
    tick;
    set_beat(1'b0, 2'd0, 8'd0, 32'h0);
    checks++; if (dut.tx_state !== TX_BODY) begin errors++; $display("FAIL mid_pre_state got %0d exp BODY", dut.tx_state); end
    arst = 1'b0;
    #2;
    checks++; if (tx_ready !== 1'b0 || send_if.req.valid !== 1'b0 || rx_valid !== 1'b0 || rx_err !== 3'b000 || recv_if.resp.ready !== 1'b0)
      begin errors++; $display("FAIL mid_reset_outs got txr=%b sv=%b rxv=%b err=%b rr=%b exp all 0", tx_ready, send_if.req.valid, rx_valid, rx_err, recv_if.resp.ready); end
    tick;
    arst = 1'b1;
    tick;
    checks++; if (tx_ready !== 1'b1 || send_if.req.valid !== 1'b0)
      begin errors++; $display("FAIL mid_release got txr=%b sv=%b exp txr=1 sv=0", tx_ready, send_if.req.valid); end
    send_if.resp.ready = 1'b1;
    set_beat(1'b1, 2'd0, 8'd3, 32'hFFFF_FFFF);
    tick;
    set_beat(1'b0, 2'd0, 8'd0, 32'h0);
    checks++; if (send_if.req.valid !== 1'b1 || send_if.req.fdata !== {2'b00, 32'hFF03_FFFF} || send_if.req.vc_id !== 2'd0)
      begin errors++; $display("FAIL mid_first_head got v=%b f=%h vc=%0d exp v=1 f=0ff03ffff vc=0", send_if.req.valid, send_if.req.fdata, send_if.req.vc_id); end
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_tx_packet;
    test_single_flit;
    test_backpressure;
    test_rx_interleave;
    test_rx_error;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
